// File: rtl/matmul_xcel_row_feeder.sv
// Left-edge feeder for one weight-stationary PE row: weight load after reset, then skewed activation jobs.
// Defining MATMUL_XCEL_ROW_FEEDER_PERF_EN adds saturating perf_bubbles / perf_jobs counters.
module matmul_xcel_row_feeder #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_PES   = 4,
    parameter int ROW_IDX   = 0,
    parameter int MAX_ACTS  = 16,
    localparam int CNT_W    = $clog2(MAX_ACTS + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cfg_val,
    output logic                 cfg_rdy,
    input  logic [CNT_W-1:0]     cfg_num_acts,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic [BIT_WIDTH-1:0] o_data,
    output logic                 o_wr_weight_ena,
    output logic                 busy,
    output logic                 done,
    output logic                 err_underrun
`ifdef MATMUL_XCEL_ROW_FEEDER_PERF_EN
    ,
    output logic [15:0]          perf_bubbles,
    output logic [15:0]          perf_jobs
`endif
);

    // state    | meaning
    // S_LOAD_W | shifting NUM_PES weights into the row, farthest PE first
    // S_IDLE   | waiting for a job descriptor
    // S_STREAM | accepting the job's activations
    // S_DRAIN  | last activation travelling through the skew pipeline

    localparam int D      = ROW_IDX + 1;
    localparam int WCNT_W = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;
    localparam int DCNT_W = $clog2(D + 1);

    typedef enum logic [1:0] {S_LOAD_W, S_IDLE, S_STREAM, S_DRAIN} state_e;

    state_e               state_q;
    logic [WCNT_W-1:0]    wcnt_q;
    logic [CNT_W-1:0]     acnt_q;
    logic [CNT_W-1:0]     num_acts_q;
    logic [DCNT_W-1:0]    dcnt_q;
    logic                 done_q;
    logic                 err_q;
    logic [BIT_WIDTH-1:0] pipe_data_q [D];
    logic                 pipe_ena_q  [D];

    logic                 in_fire;
    logic                 cfg_fire;
    logic [CNT_W-1:0]     num_acts_d;
    logic [BIT_WIDTH-1:0] s0_data_d;
    logic                 s0_ena_d;

    // Ready depends on state alone so there is never a val->rdy path.
    always_comb begin
        in_rdy  = (state_q == S_LOAD_W) || (state_q == S_STREAM);
        cfg_rdy = (state_q == S_IDLE);
    end

    assign busy     = (state_q != S_IDLE);
    assign in_fire  = in_val && in_rdy;
    assign cfg_fire = cfg_val && cfg_rdy;

    always_comb begin
        num_acts_d = cfg_num_acts;
        if (cfg_num_acts > CNT_W'(MAX_ACTS)) begin
            num_acts_d = CNT_W'(MAX_ACTS);
        end
    end

    always_comb begin
        s0_data_d = '0;
        s0_ena_d  = 1'b0;
        if (in_fire) begin
            s0_data_d = in_data;
            s0_ena_d  = (state_q == S_LOAD_W);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < D; i++) begin
                pipe_data_q[i] <= '0;
                pipe_ena_q[i]  <= 1'b0;
            end
        end else begin
            pipe_data_q[0] <= s0_data_d;
            pipe_ena_q[0]  <= s0_ena_d;
            for (int i = 1; i < D; i++) begin
                pipe_data_q[i] <= pipe_data_q[i-1];
                pipe_ena_q[i]  <= pipe_ena_q[i-1];
            end
        end
    end

    assign o_data          = pipe_data_q[D-1];
    assign o_wr_weight_ena = pipe_ena_q[D-1];
    assign done            = done_q;
    assign err_underrun    = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_LOAD_W;
            wcnt_q     <= '0;
            acnt_q     <= '0;
            num_acts_q <= '0;
            dcnt_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_LOAD_W: begin
                    if (in_fire) begin
                        if (wcnt_q == WCNT_W'(NUM_PES - 1)) begin
                            state_q <= S_IDLE;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (cfg_fire) begin
                        if (num_acts_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            num_acts_q <= num_acts_d;
                            acnt_q     <= '0;
                            state_q    <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (in_fire) begin
                        if (acnt_q == num_acts_q - 1'b1) begin
                            state_q <= S_DRAIN;
                            dcnt_q  <= DCNT_W'(D - 1);
                            acnt_q  <= '0;
                            // With no skew the last beat is already on o_data next cycle.
                            done_q  <= (D == 1);
                        end else begin
                            acnt_q <= acnt_q + 1'b1;
                        end
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (dcnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        dcnt_q <= dcnt_q - 1'b1;
                        done_q <= (dcnt_q == DCNT_W'(1));
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef MATMUL_XCEL_ROW_FEEDER_PERF_EN
    logic [15:0] perf_bubbles_q;
    logic [15:0] perf_jobs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_bubbles_q <= '0;
            perf_jobs_q    <= '0;
        end else begin
            if ((state_q == S_STREAM) && !in_val && (perf_bubbles_q != 16'hFFFF)) begin
                perf_bubbles_q <= perf_bubbles_q + 16'd1;
            end
            if (done_q && (perf_jobs_q != 16'hFFFF)) begin
                perf_jobs_q <= perf_jobs_q + 16'd1;
            end
        end
    end

    assign perf_bubbles = perf_bubbles_q;
    assign perf_jobs    = perf_jobs_q;
`endif

endmodule

// File: tb/tb_matmul_xcel_row_feeder.sv
// Scoreboard bench for matmul_xcel_row_feeder with ROW_IDX=2 (three-stage skew).
// Perf counter checks are compiled in when MATMUL_XCEL_ROW_FEEDER_PERF_EN is defined.
`timescale 1ns/1ps
module tb_matmul_xcel_row_feeder;

    localparam int BW = 8;
    localparam int NP = 4;
    localparam int RI = 2;
    localparam int MA = 16;
    localparam int D  = RI + 1;
    localparam int CW = $clog2(MA + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_val = 1'b0;
    logic          cfg_rdy;
    logic [CW-1:0] cfg_num_acts = '0;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [BW-1:0] in_data = '0;
    logic [BW-1:0] o_data;
    logic          o_wr_weight_ena;
    logic          busy;
    logic          done;
    logic          err_underrun;
`ifdef MATMUL_XCEL_ROW_FEEDER_PERF_EN
    logic [15:0]   perf_bubbles;
    logic [15:0]   perf_jobs;
`endif

    matmul_xcel_row_feeder #(
        .BIT_WIDTH(BW),
        .NUM_PES  (NP),
        .ROW_IDX  (RI),
        .MAX_ACTS (MA)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_val        (cfg_val),
        .cfg_rdy        (cfg_rdy),
        .cfg_num_acts   (cfg_num_acts),
        .in_val         (in_val),
        .in_rdy         (in_rdy),
        .in_data        (in_data),
        .o_data         (o_data),
        .o_wr_weight_ena(o_wr_weight_ena),
        .busy           (busy),
        .done           (done),
        .err_underrun   (err_underrun)
`ifdef MATMUL_XCEL_ROW_FEEDER_PERF_EN
        ,
        .perf_bubbles   (perf_bubbles),
        .perf_jobs      (perf_jobs)
`endif
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges since reset release
    int cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct {
        int            due;
        logic [BW-1:0] data;
        logic          ena;
    } beat_t;

    beat_t sb_q[$];
    int    done_due_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;

    logic [BW-1:0] mon_d;
    logic          mon_e;
    logic          mon_done;

    // Every cycle the row output must be either the scheduled beat or a {0,0} bubble.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_d    = '0;
            mon_e    = 1'b0;
            mon_done = 1'b0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                mon_d = sb_q[0].data;
                mon_e = sb_q[0].ena;
                sb_q.delete(0);
            end
            if (done_due_q.size() > 0 && done_due_q[0] == cyc) begin
                mon_done = 1'b1;
                done_due_q.delete(0);
            end
            n_cmp++;
            if (o_data !== mon_d || o_wr_weight_ena !== mon_e || done !== mon_done) begin
                n_err++;
                $display("FAIL row_out cyc=%0d: got data=%0d ena=%b done=%b, expected data=%0d ena=%b done=%b",
                         cyc, o_data, o_wr_weight_ena, done, mon_d, mon_e, mon_done);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [BW-1:0] d, input logic e, output int c);
        n_cmp++;
        if (in_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL in_rdy_before_beat cyc=%0d: got %b, expected 1", cyc, in_rdy);
        end
        c       = cyc;
        in_val  = 1'b1;
        in_data = d;
        sb_q.push_back('{due: cyc + D, data: d, ena: e});
        tick(1);
        in_val  = 1'b0;
        in_data = '0;
    endtask

    task automatic drive_cfg(input logic [CW-1:0] n, output int c);
        n_cmp++;
        if (cfg_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_rdy_before_cfg cyc=%0d: got %b, expected 1", cyc, cfg_rdy);
        end
        c            = cyc;
        cfg_val      = 1'b1;
        cfg_num_acts = n;
        tick(1);
        cfg_val      = 1'b0;
        cfg_num_acts = '0;
    endtask

    task automatic load_weights(input logic [BW-1:0] base);
        int c;
        for (int i = 0; i < NP; i++) drive_beat(base - BW'(i), 1'b1, c);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        tick(2);
        n_cmp++;
        if ({o_data, o_wr_weight_ena, done, err_underrun, cfg_rdy, in_rdy, busy} !== {8'd0, 6'b000011}) begin
            n_err++;
            $display("FAIL reset_held: got data=%0d ena=%b done=%b err=%b cfg_rdy=%b in_rdy=%b busy=%b, expected 0 0 0 0 0 1 1",
                     o_data, o_wr_weight_ena, done, err_underrun, cfg_rdy, in_rdy, busy);
        end
        reset_n = 1'b1;
        mon_en  = 1'b1;
        n_cmp++;
        if ({cfg_rdy, in_rdy, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL reset_release_state: got cfg_rdy/in_rdy/busy=%b, expected 011", {cfg_rdy, in_rdy, busy});
        end
    endtask

    task automatic test_weight_load();
        load_weights(8'd4);
        n_cmp++;
        if ({cfg_rdy, in_rdy, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL load_to_idle: got cfg_rdy/in_rdy/busy=%b, expected 100", {cfg_rdy, in_rdy, busy});
        end
        tick(D + 1);
    endtask

    task automatic test_stream();
        int c;
        drive_cfg(CW'(3), c);
        n_cmp++;
        if ({cfg_rdy, in_rdy, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL stream_entry: got cfg_rdy/in_rdy/busy=%b, expected 011", {cfg_rdy, in_rdy, busy});
        end
        drive_beat(8'd5, 1'b0, c);
        drive_beat(8'd6, 1'b0, c);
        drive_beat(8'd7, 1'b0, c);
        done_due_q.push_back(c + D);
        n_cmp++;
        if ({cfg_rdy, in_rdy, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL drain_state: got cfg_rdy/in_rdy/busy=%b, expected 001", {cfg_rdy, in_rdy, busy});
        end
        tick(D);
        n_cmp++;
        if ({cfg_rdy, busy, err_underrun} !== 3'b100) begin
            n_err++;
            $display("FAIL stream_end: got cfg_rdy/busy/err=%b, expected 100", {cfg_rdy, busy, err_underrun});
        end
    endtask

    task automatic test_bubble();
        int c;
        drive_cfg(CW'(2), c);
        drive_beat(8'd9, 1'b0, c);
        in_data = 8'h5A;
        tick(1);
        in_data = '0;
        n_cmp++;
        if (err_underrun !== 1'b1) begin
            n_err++;
            $display("FAIL err_set: got %b, expected 1", err_underrun);
        end
        drive_beat(8'd10, 1'b0, c);
        done_due_q.push_back(c + D);
        tick(D);
        drive_cfg(CW'(1), c);
        drive_beat(8'd11, 1'b0, c);
        done_due_q.push_back(c + D);
        tick(D);
        n_cmp++;
        if ({err_underrun, cfg_rdy} !== 2'b11) begin
            n_err++;
            $display("FAIL err_sticky: got err/cfg_rdy=%b, expected 11", {err_underrun, cfg_rdy});
        end
    endtask

    task automatic test_zero_clamp();
        int c;
        drive_cfg(CW'(0), c);
        done_due_q.push_back(c + 1);
        n_cmp++;
        if ({cfg_rdy, in_rdy, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL zero_len_idle: got cfg_rdy/in_rdy/busy=%b, expected 100", {cfg_rdy, in_rdy, busy});
        end
        tick(1);
        drive_cfg(CW'(MA + 3), c);
        for (int i = 0; i < MA; i++) drive_beat(BW'(20 + i), 1'b0, c);
        done_due_q.push_back(c + D);
        n_cmp++;
        if (in_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL clamp_count: got in_rdy=%b after %0d beats, expected 0", in_rdy, MA);
        end
        in_val  = 1'b1;
        in_data = 8'd99;
        tick(D);
        n_cmp++;
        if ({cfg_rdy, in_rdy} !== 2'b10) begin
            n_err++;
            $display("FAIL clamp_idle: got cfg_rdy/in_rdy=%b, expected 10", {cfg_rdy, in_rdy});
        end
        tick(1);
        in_val  = 1'b0;
        in_data = '0;
    endtask

    task automatic test_async_reset();
        int c;
        drive_cfg(CW'(4), c);
        drive_beat(8'd31, 1'b0, c);
        drive_beat(8'd32, 1'b0, c);
        drive_beat(8'd33, 1'b0, c);
        n_cmp++;
        if (o_data !== 8'd31) begin
            n_err++;
            $display("FAIL pre_reset_data: got %0d, expected 31", o_data);
        end
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        sb_q.delete();
        done_due_q.delete();
        #1;
        n_cmp++;
        if ({o_data, o_wr_weight_ena, done, err_underrun, cfg_rdy, in_rdy, busy} !== {8'd0, 6'b000011}) begin
            n_err++;
            $display("FAIL async_reset: got data=%0d ena=%b done=%b err=%b cfg_rdy=%b in_rdy=%b busy=%b, expected 0 0 0 0 0 1 1",
                     o_data, o_wr_weight_ena, done, err_underrun, cfg_rdy, in_rdy, busy);
        end
        tick(2);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        load_weights(8'd43);
        n_cmp++;
        if ({cfg_rdy, in_rdy, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL reload_to_idle: got cfg_rdy/in_rdy/busy=%b, expected 100", {cfg_rdy, in_rdy, busy});
        end
        tick(D + 1);
    endtask

    task automatic test_back_to_back();
        int c;
        drive_cfg(CW'(2), c);
        drive_beat(8'd1, 1'b0, c);
        tick(1);
        drive_beat(8'd2, 1'b0, c);
        done_due_q.push_back(c + D);
        tick(D);
        drive_cfg(CW'(0), c);
        done_due_q.push_back(c + 1);
        drive_cfg(CW'(2), c);
        drive_beat(8'd3, 1'b0, c);
        tick(1);
        drive_beat(8'd4, 1'b0, c);
        done_due_q.push_back(c + D);
        tick(D + 2);
        n_cmp++;
        if ({err_underrun, cfg_rdy} !== 2'b11) begin
            n_err++;
            $display("FAIL b2b_end: got err/cfg_rdy=%b, expected 11", {err_underrun, cfg_rdy});
        end
`ifdef MATMUL_XCEL_ROW_FEEDER_PERF_EN
        n_cmp++;
        if (perf_jobs !== 16'd3 || perf_bubbles !== 16'd2) begin
            n_err++;
            $display("FAIL perf_counts: got jobs=%0d bubbles=%0d, expected jobs=3 bubbles=2", perf_jobs, perf_bubbles);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_stream();
        test_bubble();
        test_zero_clamp();
        test_async_reset();
        test_back_to_back();
        tick(2);
        n_cmp++;
        if (sb_q.size() != 0 || done_due_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drained: got %0d beats / %0d dones pending, expected 0 / 0",
                     sb_q.size(), done_due_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
